// File: rtl/reg_file_pkg.sv
// Shared register-file constants for decode, execute and the register file.
// Referenced by reg_file, reg_file_rport and the pipeline stages around them.
package reg_file_pkg;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [REG_ADDR_W-1:0] RA_REG   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] SP_REG   = 5'd2;
endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port of the register file: x0 reads as zero.
// With REG_FILE_BYPASS_EN defined, a same-cycle committing write is forwarded.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] regs [1:(1<<ADDR_W)-1],
`ifdef REG_FILE_BYPASS_EN
    input  logic              byp_vld,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
`endif
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if (raddr != '0) begin
`ifdef REG_FILE_BYPASS_EN
            // byp_vld already excludes reset and writes to x0
            if (byp_vld && (byp_addr == raddr))
                rdata = byp_data;
            else
                rdata = regs[raddr];
`else
            rdata = regs[raddr];
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file x0..x31 with two read ports, a debug port
// and a committed-write counter. Optional macro: REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int          ADDR_W  = REG_ADDR_W,
    parameter int          DATA_W  = REG_DATA_W,
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_raddr,
    output logic [DATA_W-1:0] rs1_rdata,
    input  logic [ADDR_W-1:0] rs2_raddr,
    output logic [DATA_W-1:0] rs2_rdata,
    input  logic              rd_wen,
    input  logic [ADDR_W-1:0] rd_waddr,
    input  logic [DATA_W-1:0] rd_wdata,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [31:0]       wr_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [31:0]       r_wr_count;
    logic              w_commit;

    assign w_commit = rd_wen && !rst && (rd_waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++)
                r_regs[i] <= (i == int'(SP_REG)) ? DATA_W'(SP_INIT) : '0;
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[rd_waddr] <= rd_wdata;
            r_wr_count       <= r_wr_count + 32'd1;
        end
    end

    reg_file_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rs1 (
        .raddr    (rs1_raddr),
        .regs     (r_regs),
`ifdef REG_FILE_BYPASS_EN
        .byp_vld  (w_commit),
        .byp_addr (rd_waddr),
        .byp_data (rd_wdata),
`endif
        .rdata    (rs1_rdata)
    );

    reg_file_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rs2 (
        .raddr    (rs2_raddr),
        .regs     (r_regs),
`ifdef REG_FILE_BYPASS_EN
        .byp_vld  (w_commit),
        .byp_addr (rd_waddr),
        .byp_data (rd_wdata),
`endif
        .rdata    (rs2_rdata)
    );

    // Debug reads the stored array only, so it always shows the pre-write value
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];
    assign wr_count  = r_wr_count;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural integer register file (x0..x31) for the 3-stage RV32I core.
- Sits between decode and execute. Decode reads rs1/rs2 through it. The execute stage's rd_data is written back into it at the end of the execute cycle.
- Also carries a free-running count of committed register writes, used for bring-up and performance checks.

Parameters:
- ADDR_W, 5, register index width (32 registers).
- DATA_W, 32, register data width.
- SP_INIT, 32'h0000_0000, value loaded into x2 (sp) on reset; every other register resets to 0.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_raddr  input  5  read port 1 index (from decode).
- rs1_rdata  output  32  read port 1 data, combinational.
- rs2_raddr  input  5  read port 2 index (from decode).
- rs2_rdata  output  32  read port 2 data, combinational.
- rd_wen  input  1  write enable from execute.
- rd_waddr  input  5  write index.
- rd_wdata  input  32  write data (execute rd_data).
- dbg_raddr  input  5  debug read index.
- dbg_rdata  output  32  debug read data, combinational, never bypassed.
- wr_count  output  32  number of committed writes to x1..x31.

Behaviour:
- Storage: 31 registers of DATA_W flops (x1..x31). x0 has no storage.
- Reads:
  - Any read of index 0 returns 0, regardless of writes or bypass.
  - Read latency is 0 cycles (combinational from the address and array).
- Write:
  - At posedge clk, if rd_wen=1, rst=0 and rd_waddr!=0, then reg[rd_waddr] <= rd_wdata.
  - A write to x0 is discarded and does not count.
- Reset:
  - At posedge clk with rst=1: all registers clear to 0, x2 takes SP_INIT, and wr_count clears to 0.
  - A write presented in the same cycle as rst=1 is ignored.
  - Reset asserted mid-program takes effect at the next edge, with no partial state.
- Output values during and after reset:
  - rs1_rdata, rs2_rdata and dbg_rdata reflect the cleared array: 0, or SP_INIT when index 2 is selected.
  - wr_count = 0.
- wr_count:
  - Increments by 1 on every edge where a write actually commits (rd_wen=1, rd_waddr!=0, rst=0).
  - Wraps from 32'hFFFF_FFFF to 0 without saturating and without a flag.
- Simultaneous events:
  - rs1_raddr and rs2_raddr may be equal; both ports return the same value.
  - A read of the index being written in the same cycle follows the Optional Feature below.
  - dbg_rdata always returns the pre-write (stored) value.
- Unknown inputs: when rd_wen=0, rd_waddr and rd_wdata are don't-care and must not alter state.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding is enabled. If rd_wen=1, rd_waddr!=0 and rd_waddr==rsN_raddr, then rsN_rdata = rd_wdata in that same cycle.
  - Removes the one-cycle RAW hazard between execute and decode in the 3-stage pipe.
  - Forwarding is suppressed while rst=1.
- Not defined:
  - rsN_rdata always returns the stored value, so a same-cycle write is visible only from the next cycle.
  - Control must stall decode for one cycle on a RAW match.

Decomposition:
- Shared package:
  - REG_NUM=32, REG_ADDR_W=5, REG_DATA_W=32.
  - Register index constants ZERO_REG=0, RA_REG=1, SP_REG=2.
  - Shared by decode, execute and this block.
- One sub-module, reg_file_rport: a single combinational read port (index-0 zeroing, plus the optional bypass mux). It is instantiated twice (rs1, rs2). The debug port uses the array directly.

Test Plan:
- Reset with SP_INIT=32'h0000_1000, then read x2 and x5 → rs1_rdata=32'h0000_1000, rs2_rdata=0, wr_count=0.
- Write x5=32'hDEAD_BEEF (rd_wen=1), next cycle read rs1=x5 and rs2=x0 → 32'hDEAD_BEEF and 0; wr_count=1.
- Write x0=32'hFFFF_FFFF → read x0=0; wr_count unchanged.
- Same-cycle write x7=32'h1234_5678 with rs1_raddr=7:
  - with REG_FILE_BYPASS_EN: rs1_rdata=32'h1234_5678 in that cycle;
  - without it: old value (0), then 32'h1234_5678 the next cycle;
  - dbg_rdata shows 0 in that cycle in both builds.
- Assert rst in the same cycle as a write x9=32'hA5A5_A5A5 → x9 reads 0 afterwards and wr_count=0.
- Force wr_count to 32'hFFFF_FFFE (via a bench backdoor or 2^32-2 writes), then do 2 committed writes → wr_count=0 with no other side effect.
